// File: rtl/uart_frame_assembler.sv
// Collects seven UART bytes into a 56-bit {cmd, addr, wdata} command frame and
// offers it downstream with valid/ready, flagging receive, opcode, timeout and overrun errors.
module uart_frame_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 8192,
    parameter logic [7:0]  CMD_WREQ       = 8'h01,
    parameter logic [7:0]  CMD_RREQ       = 8'h02
) (
    input  logic        clk_uart,
    input  logic        rst_uart,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    input  logic        frame_ready,
    output logic [55:0] frame_data,
    output logic        frame_valid,
    output logic        frame_write,
    output logic        busy,
    output logic        err_rx,
    output logic        err_opcode,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_SLOT = 3'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [2:0]    byte_cnt, byte_cnt_next;
    logic [TW-1:0] to_cnt, to_cnt_next;
    logic [55:0]   data_next;
    logic          write_next;
    logic          err_rx_next, err_opcode_next, err_timeout_next, err_overrun_next;
    logic          is_opcode;

    assign is_opcode = (rx_data == CMD_WREQ) || (rx_data == CMD_RREQ);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
        state_next       = state;
        byte_cnt_next    = byte_cnt;
        to_cnt_next      = to_cnt;
        data_next        = frame_data;
        write_next       = frame_write;
        err_rx_next      = 1'b0;
        err_opcode_next  = 1'b0;
        err_timeout_next = 1'b0;
        err_overrun_next = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        err_rx_next = 1'b1;
                    end else if (is_opcode) begin
                        data_next[55:48] = rx_data;
                        byte_cnt_next    = 3'd1;
                        to_cnt_next      = '0;
                        state_next       = COLLECT;
                    end else begin
                        err_opcode_next = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        err_rx_next   = 1'b1;
                        byte_cnt_next = '0;
                        to_cnt_next   = '0;
                        state_next    = IDLE;
                    end else begin
                        // Byte k of the frame lands in bits [55-8k -: 8].
                        for (int k = 1; k < 7; k++) begin
                            if (byte_cnt == 3'(k)) begin
                                data_next[55-8*k -: 8] = rx_data;
                            end
                        end
                        byte_cnt_next = byte_cnt + 3'd1;
                        to_cnt_next   = '0;
                        if (byte_cnt == LAST_SLOT) begin
                            write_next = (frame_data[55:48] == CMD_WREQ);
                            state_next = HOLD;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_timeout_next = 1'b1;
                    byte_cnt_next    = '0;
                    to_cnt_next      = '0;
                    state_next       = IDLE;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                end
            end

            HOLD: begin
                // Any byte arriving here is dropped, even in the transfer cycle.
                if (rx_valid) begin
                    err_overrun_next = 1'b1;
                end
                if (frame_ready) begin
                    byte_cnt_next = '0;
                    state_next    = IDLE;
                end
            end

            default: begin
                byte_cnt_next = '0;
                to_cnt_next   = '0;
                state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_uart) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst_uart) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            frame_data  <= '0;
            frame_write <= 1'b0;
            err_rx      <= 1'b0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_next;
            byte_cnt    <= byte_cnt_next;
            to_cnt      <= to_cnt_next;
            frame_data  <= data_next;
            frame_write <= write_next;
            err_rx      <= err_rx_next;
            err_opcode  <= err_opcode_next;
            err_timeout <= err_timeout_next;
            err_overrun <= err_overrun_next;
        end
    end

    assign frame_valid = (state == HOLD);
    assign busy        = (state != IDLE);

endmodule
